// File: rtl/que_pair_if.sv
// Bus bundle for the pairing queue: operand input handshake, pair-FIFO head and final-result outputs.
interface que_pair_if #(
    parameter int unsigned WID_D  = 32,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned ADDR_W = 5
) ();
    logic [WID_D-1:0]  data_in;
    logic [CNT_W-1:0]  order_cnt;
    logic              dt_vld_in;
    logic              dt_rdy_o;
    logic              mux2que_rdy;
    logic [WID_D-1:0]  a_left;
    logic [WID_D-1:0]  a_right;
    logic [CNT_W-1:0]  order_cnt_o;
    logic              dt_vld_o;
    logic [ADDR_W:0]   fifo_cnt;
    logic [WID_D-1:0]  data_cal_out;
    logic              data_out_vld;
    logic              err_ord;

    modport master (
        output data_in, order_cnt, dt_vld_in, mux2que_rdy,
        input  dt_rdy_o, a_left, a_right, order_cnt_o, dt_vld_o,
               fifo_cnt, data_cal_out, data_out_vld, err_ord
    );

    modport slave (
        input  data_in, order_cnt, dt_vld_in, mux2que_rdy,
        output dt_rdy_o, a_left, a_right, order_cnt_o, dt_vld_o,
               fifo_cnt, data_cal_out, data_out_vld, err_ord
    );
endinterface

// File: rtl/que_pair_ctrl.sv
// Pairing queue for the reduction tree: matches operands per order index and
// queues {left, right, index} pairs in a show-ahead circular FIFO.
module que_pair_ctrl #(
    parameter int unsigned WID_D    = 32,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned ORD_NUM  = 30,
    parameter int unsigned FIFO_DEP = 17,
    parameter int unsigned ADDR_W   = $clog2(FIFO_DEP)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    que_pair_if.slave   bus
);
    localparam int unsigned CNT_BITS = ADDR_W + 1;

    logic [ORD_NUM-1:0]  flag_q;
    logic [WID_D-1:0]    slot_q [ORD_NUM];
    logic [WID_D-1:0]    mem_l  [FIFO_DEP];
    logic [WID_D-1:0]    mem_r  [FIFO_DEP];
    logic [CNT_W-1:0]    mem_k  [FIFO_DEP];
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WID_D-1:0]    cal_q;
    logic                out_vld_q;
    logic                err_q;

    logic [CNT_W-1:0]    idx_c;
    logic                in_slot_c;
    logic                in_final_c;
    logic                in_err_c;
    logic                full_c;
    logic                rdy_c;
    logic                acc_c;
    logic                push_c;
    logic                pop_c;
    logic                not_empty_c;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(FIFO_DEP - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    always_comb begin
        idx_c       = bus.order_cnt;
        in_slot_c   = (bus.order_cnt <  CNT_W'(ORD_NUM));
        in_final_c  = (bus.order_cnt == CNT_W'(ORD_NUM));
        in_err_c    = (bus.order_cnt >  CNT_W'(ORD_NUM));
        full_c      = (cnt_q == CNT_BITS'(FIFO_DEP));
        not_empty_c = (cnt_q != '0);
        rdy_c       = !full_c && !flush;
        acc_c       = bus.dt_vld_in && rdy_c;
        push_c      = acc_c && in_slot_c && flag_q[idx_c];
        pop_c       = !flush && bus.mux2que_rdy && not_empty_c;
    end

    // Pointers, occupancy, slot flags and result/error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            cal_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (flush) begin
            flag_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (acc_c && in_slot_c) begin
                flag_q[idx_c] <= !flag_q[idx_c];
            end
            if (push_c) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_c, pop_c})
                2'b10:   cnt_q <= cnt_q + CNT_BITS'(1);
                2'b01:   cnt_q <= cnt_q - CNT_BITS'(1);
                default: cnt_q <= cnt_q;
            endcase
            out_vld_q <= acc_c && in_final_c;
            if (acc_c && in_final_c) begin
                cal_q <= bus.data_in;
            end
            if (acc_c && in_err_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // Slot operand storage and FIFO entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ORD_NUM); i++) begin
                slot_q[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEP); i++) begin
                mem_l[i] <= '0;
                mem_r[i] <= '0;
                mem_k[i] <= '0;
            end
        end else begin
            if (acc_c && in_slot_c && !flag_q[idx_c]) begin
                slot_q[idx_c] <= bus.data_in;
            end
            if (push_c) begin
                mem_l[wr_ptr_q] <= slot_q[idx_c];
                mem_r[wr_ptr_q] <= bus.data_in;
                mem_k[wr_ptr_q] <= bus.order_cnt;
            end
        end
    end

    assign bus.dt_rdy_o     = rdy_c;
    assign bus.a_left       = mem_l[rd_ptr_q];
    assign bus.a_right      = mem_r[rd_ptr_q];
    assign bus.order_cnt_o  = mem_k[rd_ptr_q];
    assign bus.dt_vld_o     = not_empty_c;
    assign bus.fifo_cnt     = cnt_q;
    assign bus.data_cal_out = cal_q;
    assign bus.data_out_vld = out_vld_q;
    assign bus.err_ord      = err_q;

endmodule

// File: tb/tb_que_pair_ctrl.sv
// Scoreboard bench for que_pair_ctrl: directed pairing, full/wrap, final, error, flush and reset cases.
module tb_que_pair_ctrl;
    localparam int unsigned WID_D    = 32;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned ORD_NUM  = 30;
    localparam int unsigned FIFO_DEP = 3;
    localparam int unsigned ADDR_W   = $clog2(FIFO_DEP);

    typedef struct packed {
        logic [WID_D-1:0] l;
        logic [WID_D-1:0] r;
        logic [CNT_W-1:0] k;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    que_pair_if #(.WID_D(WID_D), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

    que_pair_ctrl #(
        .WID_D(WID_D), .CNT_W(CNT_W), .ORD_NUM(ORD_NUM),
        .FIFO_DEP(FIFO_DEP), .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    pair_t            exp_q[$];
    logic [WID_D-1:0] exp_fin[$];
    logic [WID_D-1:0] mslot [ORD_NUM];
    logic             mflag [ORD_NUM];
    int               max_cnt = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(ORD_NUM); i++) mflag[i] = 1'b0;
        exp_q.delete();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and hold it until the DUT accepts it; update the model on acceptance.
    task automatic send(input int k, input logic [WID_D-1:0] d);
        logic rdy;
        int   n;
        n = 0;
        bus.order_cnt = CNT_W'(k);
        bus.data_in   = d;
        bus.dt_vld_in = 1'b1;
        forever begin
            @(negedge clk);
            rdy = bus.dt_rdy_o;
            tick();
            if (rdy) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'(n), 64'(0));
                break;
            end
        end
        bus.dt_vld_in = 1'b0;
        if (rdy) begin
            if (k < int'(ORD_NUM)) begin
                if (mflag[k]) begin
                    exp_q.push_back('{l: mslot[k], r: d, k: CNT_W'(k)});
                    mflag[k] = 1'b0;
                end else begin
                    mslot[k] = d;
                    mflag[k] = 1'b1;
                end
            end else if (k == int'(ORD_NUM)) begin
                exp_fin.push_back(d);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.mux2que_rdy = 1'b1;
        while (bus.fifo_cnt != '0 && n < 50) begin
            tick();
            n++;
        end
        bus.mux2que_rdy = 1'b0;
        chk("drain_done", 64'(bus.fifo_cnt), 64'(0));
    endtask

    // Monitor: compare head against the scoreboard whenever a pop will occur, and each final pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(bus.fifo_cnt) > max_cnt) max_cnt = int'(bus.fifo_cnt);
            if (!flush && bus.dt_vld_o && bus.mux2que_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 64'(bus.order_cnt_o), 64'hFFFF);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("pair_left",  64'(bus.a_left),      64'(e.l));
                    chk("pair_right", 64'(bus.a_right),     64'(e.r));
                    chk("pair_index", 64'(bus.order_cnt_o), 64'(e.k));
                end
            end
            if (bus.data_out_vld) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_final", 64'(bus.data_cal_out), 64'hFFFF);
                end else begin
                    chk("final_data", 64'(bus.data_cal_out), 64'(exp_fin.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.data_in     = '0;
        bus.order_cnt   = '0;
        bus.dt_vld_in   = 1'b0;
        bus.mux2que_rdy = 1'b0;
        for (int i = 0; i < int'(ORD_NUM); i++) mslot[i] = '0;
        model_clear();
        repeat (3) tick();
        chk("rst_fifo_cnt", 64'(bus.fifo_cnt),     64'(0));
        chk("rst_dt_vld_o", 64'(bus.dt_vld_o),     64'(0));
        chk("rst_out_vld",  64'(bus.data_out_vld), 64'(0));
        chk("rst_cal_out",  64'(bus.data_cal_out), 64'(0));
        chk("rst_err_ord",  64'(bus.err_ord),      64'(0));
        chk("rst_a_left",   64'(bus.a_left),       64'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_rdy", 64'(bus.dt_rdy_o), 64'(1));

        // Basic pairing, then a fresh operand on the same index.
        send(3, 32'hA);
        chk("pair_first_no_push", 64'(bus.fifo_cnt), 64'(0));
        send(3, 32'hB);
        chk("pair_cnt",   64'(bus.fifo_cnt),    64'(1));
        chk("pair_vld",   64'(bus.dt_vld_o),    64'(1));
        chk("pair_head_l", 64'(bus.a_left),     64'hA);
        chk("pair_head_r", 64'(bus.a_right),    64'hB);
        chk("pair_head_k", 64'(bus.order_cnt_o), 64'(3));
        bus.mux2que_rdy = 1'b1;
        tick();
        bus.mux2que_rdy = 1'b0;
        chk("pop_cnt", 64'(bus.fifo_cnt), 64'(0));
        send(3, 32'hC);
        chk("refresh_no_push", 64'(bus.fifo_cnt), 64'(0));

        // Interleaved indices pair in completion order.
        send(1, 32'h11);
        send(2, 32'h21);
        send(2, 32'h22);
        send(1, 32'h12);
        chk("ilv_cnt", 64'(bus.fifo_cnt), 64'(2));
        chk("ilv_head_k", 64'(bus.order_cnt_o), 64'(2));
        drain();

        // Fill to full, hold a blocked beat, then free one entry.
        send(5, 32'h50); send(5, 32'h51);
        send(6, 32'h60); send(6, 32'h61);
        send(7, 32'h70); send(7, 32'h71);
        chk("full_cnt", 64'(bus.fifo_cnt), 64'(3));
        chk("full_rdy", 64'(bus.dt_rdy_o), 64'(0));
        bus.order_cnt = CNT_W'(8);
        bus.data_in   = 32'h80;
        bus.dt_vld_in = 1'b1;
        repeat (3) tick();
        chk("full_hold_cnt", 64'(bus.fifo_cnt), 64'(3));
        bus.mux2que_rdy = 1'b1;
        tick();
        bus.mux2que_rdy = 1'b0;
        chk("unfull_cnt", 64'(bus.fifo_cnt), 64'(2));
        chk("unfull_rdy", 64'(bus.dt_rdy_o), 64'(1));
        send(8, 32'h80);
        send(8, 32'h81);
        chk("refill_cnt", 64'(bus.fifo_cnt), 64'(3));

        // Simultaneous push and pop at occupancy 2.
        bus.mux2que_rdy = 1'b1;
        tick();
        bus.mux2que_rdy = 1'b0;
        chk("pp_pre_cnt", 64'(bus.fifo_cnt), 64'(2));
        send(9, 32'h90);
        bus.mux2que_rdy = 1'b1;
        send(9, 32'h91);
        bus.mux2que_rdy = 1'b0;
        chk("pp_cnt",    64'(bus.fifo_cnt),    64'(2));
        chk("pp_head_l", 64'(bus.a_left),      64'h80);
        chk("pp_head_k", 64'(bus.order_cnt_o), 64'(8));
        drain();

        // Continuous pop across several pointer wraps.
        max_cnt = 0;
        bus.mux2que_rdy = 1'b1;
        for (int k = 10; k < 20; k++) begin
            send(k, 32'(k << 8));
            send(k, 32'((k << 8) | 1));
        end
        drain();
        chk("wrap_max_cnt", 64'(max_cnt <= int'(FIFO_DEP)), 64'(1));

        // Final result with a pair queued, then an out-of-range index.
        send(20, 32'h1);
        send(20, 32'h2);
        send(30, 32'h5A5A);
        chk("fin_vld",  64'(bus.data_out_vld), 64'(1));
        chk("fin_data", 64'(bus.data_cal_out), 64'h5A5A);
        chk("fin_cnt",  64'(bus.fifo_cnt),     64'(1));
        tick();
        chk("fin_pulse_end", 64'(bus.data_out_vld), 64'(0));
        chk("fin_hold",      64'(bus.data_cal_out), 64'h5A5A);
        send(31, 32'hDEAD);
        chk("err_set", 64'(bus.err_ord), 64'(1));
        repeat (3) tick();
        chk("err_sticky", 64'(bus.err_ord),  64'(1));
        chk("err_cnt",    64'(bus.fifo_cnt), 64'(1));

        // Flush with an open slot and two queued pairs.
        send(4, 32'h40);
        send(21, 32'h1);
        send(21, 32'h2);
        chk("pre_flush_cnt", 64'(bus.fifo_cnt), 64'(2));
        flush = 1'b1;
        bus.order_cnt = CNT_W'(22);
        bus.data_in   = 32'hBAD;
        bus.dt_vld_in = 1'b1;
        bus.mux2que_rdy = 1'b1;
        #1;
        chk("flush_rdy", 64'(bus.dt_rdy_o), 64'(0));
        tick();
        flush = 1'b0;
        bus.dt_vld_in = 1'b0;
        bus.mux2que_rdy = 1'b0;
        model_clear();
        chk("flush_cnt",  64'(bus.fifo_cnt),     64'(0));
        chk("flush_vld",  64'(bus.dt_vld_o),     64'(0));
        chk("flush_err",  64'(bus.err_ord),      64'(0));
        chk("flush_hold", 64'(bus.data_cal_out), 64'h5A5A);
        send(4, 32'h1);
        chk("post_flush_store", 64'(bus.fifo_cnt), 64'(0));
        send(4, 32'h2);
        chk("post_flush_pair", 64'(bus.fifo_cnt), 64'(1));
        chk("post_flush_l",    64'(bus.a_left),   64'h1);
        drain();

        // Asynchronous reset mid-operation drops the half pair.
        send(6, 32'h66);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_cnt", 64'(bus.fifo_cnt), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        send(6, 32'h67);
        chk("arst_no_pair", 64'(bus.fifo_cnt), 64'(0));

        repeat (3) tick();
        chk("sb_pairs_empty", 64'(exp_q.size()),   64'(0));
        chk("sb_final_empty", 64'(exp_fin.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
